serial_byte_rx: RTL and testbench
=================================

# serial_byte_rx

Bit-serial receiver that turns an asynchronous, idle-high serial line (start bit, LSB-first data bits, one stop bit) back into parallel words. It is the receiving end of the single-bit registered serial output our transmitting blocks drive off-chip. It presents each received word downstream on a valid/ready interface through a one-entry holding register, and flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, at least 4
- DATA_BITS, 8, data bits per frame; 1 to 16
- clock  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- serial_in  in  1  asynchronous serial line, idle high
- data_out  out  DATA_BITS  received word, valid while data_valid=1
- data_valid  out  1  holding register full
- data_ready  in  1  downstream accepts data_out when data_valid & data_ready
- framing_error  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: word dropped because holding register full
- busy  out  1  FSM not in IDLE

## Operation
- Input synchronizer: 2 flops, both reset to 1. `rx_s` is the second flop. All FSM decisions use `rx_s`.
- Bit counter: $clog2(CLKS_PER_BIT) bits. Data index: $clog2(DATA_BITS+1) bits. Shift register: DATA_BITS bits. All FSM counters are cleared on every state transition.
- IDLE:
  - `rx_s`=0 -> START.
- START:
  - After CLKS_PER_BIT/2 cycles, sample `rx_s` (mid-start).
  - Sample is 1 -> false start, go to IDLE, nothing reported.
  - Sample is 0 -> DATA.
- DATA:
  - Every CLKS_PER_BIT cycles, sample `rx_s` and shift it in LSB-first; the first sample lands in bit 0.
  - After DATA_BITS samples -> STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample `rx_s`.
  - Sample is 1 -> deliver the word, go to IDLE.
  - Sample is 0 -> pulse framing_error, go to BREAK; nothing is delivered.
- BREAK:
  - Wait until `rx_s`=1, then go to IDLE.
- Returning to IDLE at mid-stop gives half a bit of slack, so back-to-back frames are received.
- Deliver, holding register empty or being drained this cycle (data_valid=0, or data_valid & data_ready):
  - data_out <= shift register.
  - data_valid <= 1.
- Deliver, holding register full and not draining (data_valid=1 & data_ready=0):
  - Keep the old data.
  - Pulse overrun; the new word is discarded.
- Handshake:
  - data_valid & data_ready with no delivery that cycle -> data_valid <= 0.
  - data_out is stable while data_valid=1 & data_ready=0.
- Reset (any time, including mid-frame):
  - State IDLE.
  - data_valid=0, data_out=0, framing_error=0, overrun=0, busy=0.
  - Shift register and counters = 0; synchronizer = 1.
  - A partial frame is lost.

## Timing
- Cycle 0 is the first rising edge at which serial_in is sampled low.
- `rx_s`=0 at cycle 2.
- The FSM is in START from cycle 3.
- Mid-start sample at cycle 2+CLKS_PER_BIT/2 (10 with defaults).
- Data bit k is sampled CLKS_PER_BIT*(k+1) cycles after mid-start.
- Stop bit is sampled CLKS_PER_BIT*(DATA_BITS+1) cycles after mid-start (cycle 154 with defaults).
- data_valid, framing_error and overrun are registered: they appear on the cycle after the stop sample (cycle 155 with defaults).
- framing_error and overrun are exactly 1 cycle wide.
- busy=1 from cycle 3 until the cycle the FSM re-enters IDLE.
- Throughput: one word per CLKS_PER_BIT*(DATA_BITS+2) cycles.
- The holding register sustains full rate when data_ready is held at 1.
- No combinational path from serial_in or data_ready to any output.

## Test plan
- **Single frame:** defaults; send 0xA5 with a 16-cycle bit period; data_ready=1. Expect data_valid high for exactly 1 cycle at cycle 155, data_out=0xA5, no error pulses.
- **Back-to-back with backpressure:** send 0x3C then 0xC3 with no idle gap; data_ready=0 until 10 cycles after the second stop bit. Expect:
  - data_out stays 0x3C;
  - overrun pulses once at the second delivery;
  - after the handshake, data_valid=0 and 0xC3 is never output.
- **Framing error:** send 0x55 with the stop bit low for 40 cycles, then idle, then 0x0F. Expect:
  - framing_error is a 1-cycle pulse;
  - no data_valid for 0x55;
  - busy stays 1 until the line returns high;
  - 0x0F is then received correctly.
- **Glitch / false start:** drive serial_in low for 5 cycles, then high. Expect:
  - busy rises, then falls at mid-start;
  - no data_valid, framing_error or overrun.
- **Reset mid-frame:** assert reset for 1 cycle during data bit 4 of 0xFF. Expect all outputs 0 on the next cycle; a following 0x81 is received correctly.
- **Drain/deliver same cycle:** hold data_valid=1 with 0x11; assert data_ready exactly on the delivery cycle of 0x22. Expect data_valid stays 1, data_out becomes 0x22, and overrun stays 0.

Source files
------------

// File: rtl/serial_byte_rx_if.sv
// serial_byte_rx_if
// Valid/ready channel that carries received words from the serial receiver
// to the downstream consumer.
//   data_out   : received word, meaningful while data_valid = 1
//   data_valid : producer holds a word
//   data_ready : consumer takes the word on a cycle where both are high
// Modports: master = the receiver (producer), slave = the consumer.
interface serial_byte_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_byte_rx.sv
// serial_byte_rx
// Receives an idle-high asynchronous serial line (start bit, LSB-first data
// bits, one stop bit) and hands each word downstream through a one-entry
// holding register on a valid/ready channel.
// Ports:
//   clock          : sole clock, rising edge
//   reset          : synchronous, active-high
//   serial_in      : asynchronous serial line, idle high
//   rxBus          : master side of serial_byte_rx_if (data_out/data_valid/data_ready)
//   framing_error  : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, word dropped because the holding register was full
//   busy           : receiver FSM is not idle
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    serial_byte_rx_if.master rxBus,
    output logic             framing_error,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [IDX_W-1:0]     dataIdx_q, dataIdx_d;
    logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
    logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
    logic                 dataValid_q, dataValid_d;
    logic                 framingError_q, framingError_d;
    logic                 overrun_q, overrun_d;
    logic                 rxMeta_q, rxSync_q;
    logic                 deliver;

    // Two-flop synchronizer for the asynchronous line. Both flops reset to the
    // idle level so a reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= serial_in;
            rxSync_q <= rxMeta_q;
        end
    end

    // State, counters, shift register and the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bitCnt_q       <= '0;
            dataIdx_q      <= '0;
            shiftReg_q     <= '0;
            dataOut_q      <= '0;
            dataValid_q    <= 1'b0;
            framingError_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bitCnt_q       <= bitCnt_d;
            dataIdx_q      <= dataIdx_d;
            shiftReg_q     <= shiftReg_d;
            dataOut_q      <= dataOut_d;
            dataValid_q    <= dataValid_d;
            framingError_q <= framingError_d;
            overrun_q      <= overrun_d;
        end
    end

    // Frame FSM. Counters restart at zero on every state change so each state
    // measures its own interval. Returning to idle at mid-stop leaves half a
    // bit of slack before the next start edge.
    always_comb begin
        state_d        = state_q;
        bitCnt_d       = bitCnt_q + 1'b1;
        dataIdx_d      = dataIdx_q;
        shiftReg_d     = shiftReg_q;
        framingError_d = 1'b0;
        deliver        = 1'b0;

        case (state_q)
            S_IDLE: begin
                bitCnt_d  = '0;
                dataIdx_d = '0;
                if (!rxSync_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bitCnt_q == HALF_LAST) begin
                    bitCnt_d = '0;
                    state_d  = rxSync_q ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (bitCnt_q == BIT_LAST) begin
                    bitCnt_d   = '0;
                    // New bits enter at the top and move down, so the first
                    // sample ends up in bit 0 once the word is complete.
                    shiftReg_d = shiftReg_q >> 1;
                    shiftReg_d[DATA_BITS-1] = rxSync_q;
                    if (dataIdx_q == IDX_LAST) begin
                        dataIdx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        dataIdx_d = dataIdx_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (bitCnt_q == BIT_LAST) begin
                    bitCnt_d = '0;
                    if (rxSync_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        framingError_d = 1'b1;
                        state_d        = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                bitCnt_d = '0;
                if (rxSync_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                bitCnt_d  = '0;
                dataIdx_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Holding register. A word that arrives while the register is being
    // drained in the same cycle replaces it without an overrun; only a full,
    // stalled register drops the incoming word.
    always_comb begin
        dataOut_d   = dataOut_q;
        dataValid_d = dataValid_q;
        overrun_d   = 1'b0;

        if (dataValid_q && rxBus.data_ready) begin
            dataValid_d = 1'b0;
        end

        if (deliver) begin
            if (!dataValid_q || rxBus.data_ready) begin
                dataOut_d   = shiftReg_q;
                dataValid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rxBus.data_out   = dataOut_q;
    assign rxBus.data_valid = dataValid_q;
    assign framing_error    = framingError_q;
    assign overrun          = overrun_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_byte_rx.sv
module tb_serial_byte_rx;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic serialIn = 1'b1;
    logic framingError;
    logic overrunPulse;
    logic busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    serial_byte_rx_if #(.DATA_BITS(8)) rxBus ();

    serial_byte_rx #(
        .CLKS_PER_BIT(16),
        .DATA_BITS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .serial_in(serialIn),
        .rxBus(rxBus),
        .framing_error(framingError),
        .overrun(overrunPulse),
        .busy(busy)
    );

    typedef struct {
        logic [7:0] data;
        int         stopLow;
        logic       expValid;
        logic [7:0] expWord;
        logic       expFe;
        int         expBusyFall;
    } vec_t;

    vec_t vecs[7];

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Edge counter; a frame's cycle numbers are taken relative to it.
    always @(posedge clock) cyc <= cyc + 1;

    logic       prevValid = 1'b0;
    logic       prevBusy = 1'b0;
    int         validRiseCyc = -1;
    int         validHighCnt = 0;
    int         validFallCnt = 0;
    int         feCnt = 0;
    int         feCyc = -1;
    int         ovCnt = 0;
    int         ovCyc = -1;
    int         busyRiseCyc = -1;
    int         busyFallCyc = -1;
    logic [7:0] acceptLog[$];

    // Observe the outputs mid-cycle, after inputs driven on the falling edge
    // have settled; valid & ready seen here is a transfer on the next edge.
    always begin
        @(negedge clock);
        #2;
        if (rxBus.data_valid && !prevValid) validRiseCyc = cyc;
        if (!rxBus.data_valid && prevValid) validFallCnt++;
        if (rxBus.data_valid) validHighCnt++;
        if (rxBus.data_valid && rxBus.data_ready) acceptLog.push_back(rxBus.data_out);
        if (framingError) begin
            feCnt++;
            feCyc = cyc;
        end
        if (overrunPulse) begin
            ovCnt++;
            ovCyc = cyc;
        end
        if (busy && !prevBusy) busyRiseCyc = cyc;
        if (!busy && prevBusy) busyFallCyc = cyc;
        prevValid = rxBus.data_valid;
        prevBusy = busy;
    end

    int baseAcc, baseFe, baseOv, baseVH, baseVF;

    task automatic snap();
        baseAcc = acceptLog.size();
        baseFe = feCnt;
        baseOv = ovCnt;
        baseVH = validHighCnt;
        baseVF = validFallCnt;
    endtask

    function automatic int lastWord();
        if (acceptLog.size() == 0) return -1;
        return int'(acceptLog[acceptLog.size()-1]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic drive(input logic v, input int n);
        serialIn = v;
        repeat (n) @(negedge clock);
    endtask

    // Sends one frame starting on the current falling edge; start is the
    // cyc value after the first edge that samples the start bit.
    task automatic applyStimulus(input logic [7:0] d, input int stopLow, output int start);
        start = cyc + 1;
        drive(1'b0, 16);
        for (int b = 0; b < 8; b++) drive(d[b], 16);
        if (stopLow > 0) drive(1'b0, stopLow);
        drive(1'b1, 16);
    endtask

    int start, start2;

    initial begin
        vecs[0] = '{8'hA5, 0,  1'b1, 8'hA5, 1'b0, 154};
        vecs[1] = '{8'h00, 0,  1'b1, 8'h00, 1'b0, 154};
        vecs[2] = '{8'hFF, 0,  1'b1, 8'hFF, 1'b0, 154};
        vecs[3] = '{8'h01, 0,  1'b1, 8'h01, 1'b0, 154};
        vecs[4] = '{8'h80, 0,  1'b1, 8'h80, 1'b0, 154};
        vecs[5] = '{8'h55, 40, 1'b0, 8'h00, 1'b1, 186};
        vecs[6] = '{8'h0F, 0,  1'b1, 8'h0F, 1'b0, 154};

        rxBus.data_ready = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset valid", int'(rxBus.data_valid), 0);
        checkOutput("reset data", int'(rxBus.data_out), 0);
        checkOutput("reset fe", int'(framingError), 0);
        checkOutput("reset ov", int'(overrunPulse), 0);
        checkOutput("reset busy", int'(busy), 0);
        reset = 1'b0;
        drive(1'b1, 10);

        // Single frames with the consumer always ready.
        for (int i = 0; i < 7; i++) begin
            snap();
            applyStimulus(vecs[i].data, vecs[i].stopLow, start);
            drive(1'b1, 30);
            checkOutput($sformatf("v%0d accepted", i), acceptLog.size() - baseAcc,
                        vecs[i].expValid ? 1 : 0);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("v%0d word", i), lastWord(), int'(vecs[i].expWord));
                checkOutput($sformatf("v%0d valid rise", i), validRiseCyc - start, 154);
                checkOutput($sformatf("v%0d valid width", i), validHighCnt - baseVH, 1);
            end
            checkOutput($sformatf("v%0d fe count", i), feCnt - baseFe, vecs[i].expFe ? 1 : 0);
            if (vecs[i].expFe) begin
                checkOutput($sformatf("v%0d fe cycle", i), feCyc - start, 154);
            end
            checkOutput($sformatf("v%0d ov count", i), ovCnt - baseOv, 0);
            checkOutput($sformatf("v%0d busy rise", i), busyRiseCyc - start, 2);
            checkOutput($sformatf("v%0d busy fall", i), busyFallCyc - start, vecs[i].expBusyFall);
        end

        // Glitch: five low cycles are rejected at the mid-start sample.
        snap();
        start = cyc + 1;
        drive(1'b0, 5);
        drive(1'b1, 30);
        checkOutput("glitch busy rise", busyRiseCyc - start, 2);
        checkOutput("glitch busy fall", busyFallCyc - start, 10);
        checkOutput("glitch valid", validHighCnt - baseVH, 0);
        checkOutput("glitch fe", feCnt - baseFe, 0);
        checkOutput("glitch ov", ovCnt - baseOv, 0);

        // Back-to-back frames into a stalled consumer.
        rxBus.data_ready = 1'b0;
        snap();
        applyStimulus(8'h3C, 0, start);
        applyStimulus(8'hC3, 0, start2);
        drive(1'b1, 10);
        checkOutput("b2b valid held", int'(rxBus.data_valid), 1);
        checkOutput("b2b data held", int'(rxBus.data_out), 8'h3C);
        checkOutput("b2b ov count", ovCnt - baseOv, 1);
        checkOutput("b2b ov cycle", ovCyc - start2, 154);
        checkOutput("b2b none taken", acceptLog.size() - baseAcc, 0);
        rxBus.data_ready = 1'b1;
        @(negedge clock);
        rxBus.data_ready = 1'b0;
        checkOutput("b2b valid drained", int'(rxBus.data_valid), 0);
        drive(1'b1, 20);
        checkOutput("b2b taken", acceptLog.size() - baseAcc, 1);
        checkOutput("b2b taken word", lastWord(), 8'h3C);
        checkOutput("b2b data after", int'(rxBus.data_out), 8'h3C);
        checkOutput("b2b valid after", int'(rxBus.data_valid), 0);

        // Reset during data bit 4 of 0xFF, then a clean 0x81.
        start = cyc + 1;
        drive(1'b0, 16);
        drive(1'b1, 16 * 4 + 5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst valid", int'(rxBus.data_valid), 0);
        checkOutput("rst data", int'(rxBus.data_out), 0);
        checkOutput("rst fe", int'(framingError), 0);
        checkOutput("rst ov", int'(overrunPulse), 0);
        checkOutput("rst busy", int'(busy), 0);
        drive(1'b1, 40);
        rxBus.data_ready = 1'b1;
        snap();
        applyStimulus(8'h81, 0, start);
        drive(1'b1, 30);
        checkOutput("post-rst taken", acceptLog.size() - baseAcc, 1);
        checkOutput("post-rst word", lastWord(), 8'h81);
        checkOutput("post-rst fe", feCnt - baseFe, 0);

        // Drain and deliver on the same edge.
        rxBus.data_ready = 1'b0;
        applyStimulus(8'h11, 0, start);
        drive(1'b1, 20);
        checkOutput("drain pre valid", int'(rxBus.data_valid), 1);
        checkOutput("drain pre data", int'(rxBus.data_out), 8'h11);
        snap();
        fork
            applyStimulus(8'h22, 0, start);
            begin
                repeat (154) @(negedge clock);
                rxBus.data_ready = 1'b1;
                @(negedge clock);
                rxBus.data_ready = 1'b0;
            end
        join
        drive(1'b1, 20);
        checkOutput("drain taken", acceptLog.size() - baseAcc, 1);
        checkOutput("drain taken word", lastWord(), 8'h11);
        checkOutput("drain ov", ovCnt - baseOv, 0);
        checkOutput("drain no valid drop", validFallCnt - baseVF, 0);
        checkOutput("drain valid", int'(rxBus.data_valid), 1);
        checkOutput("drain new data", int'(rxBus.data_out), 8'h22);
        rxBus.data_ready = 1'b1;
        drive(1'b1, 5);
        checkOutput("drain final word", lastWord(), 8'h22);
        checkOutput("drain final valid", int'(rxBus.data_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
